booth_r4_ctrl: RTL and testbench

//   Sequencer for the radix-4 (modified Booth) signed multiplier datapath. Accepts one

---
 rtl/booth_r4_ctrl.sv | 125 ++++++++++++
 tb/tb_booth_r4_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_ctrl.sv
// rtl/booth_r4_ctrl.sv - radix-4 Booth signed multiplier sequencer with valid/ready ports
module booth_r4_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy
);
    // P = {A, Q, q_m1}; A carries two guard bits so -2^(W-1) squared cannot overflow
    localparam int PW = 2*WIDTH + 3;
    localparam int AW = WIDTH + 2;
    localparam int CW = (WIDTH/2 > 1) ? $clog2(WIDTH/2) : 1;

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_r4_ctrl: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SH1  = 3'd2,
        S_SH2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PW-1:0]       r_p;
    logic [AW-1:0]       r_m;
    logic [CW-1:0]       r_cnt;
    logic [2*WIDTH-1:0]  r_product;
    logic [AW-1:0]       w_pp;
    logic [AW-1:0]       w_sum;
    logic [PW-1:0]       w_shift;
    logic                w_last;

    assign w_sum   = r_p[PW-1 -: AW] + w_pp;
    assign w_shift = {r_p[PW-1], r_p[PW-1:1]};
    assign w_last  = (r_cnt == CW'(WIDTH/2 - 1));

    assign o_ready   = (r_state == S_IDLE);
    assign o_valid   = (r_state == S_DONE);
    assign o_busy    = (r_state == S_ADD) || (r_state == S_SH1) || (r_state == S_SH2);
    assign o_product = r_product;

    // Booth digit decode of {Q[1:0], q_m1} into the partial product added to A
    always_comb begin
        w_pp = '0;
        case (r_p[2:0])
            3'b001, 3'b010: w_pp = r_m;
            3'b011:         w_pp = {r_m[AW-2:0], 1'b0};
            3'b100:         w_pp = AW'(0) - {r_m[AW-2:0], 1'b0};
            3'b101, 3'b110: w_pp = AW'(0) - r_m;
            default:        w_pp = '0;
        endcase
    end

    // Next-state logic: one add and two shifts per digit, then hold until consumed
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_next = S_ADD;
            S_ADD:   w_next = S_SH1;
            S_SH1:   w_next = S_SH2;
            S_SH2:   w_next = w_last ? S_DONE : S_ADD;
            S_DONE:  if (i_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Accumulator, multiplicand, digit counter and product output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p       <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_m   <= {{2{i_multiplicand[WIDTH-1]}}, i_multiplicand};
                        r_p   <= {{AW{1'b0}}, i_multiplier, 1'b0};
                        r_cnt <= '0;
                    end
                end
                S_ADD: begin
                    r_p[PW-1 -: AW] <= w_sum;
                end
                S_SH1: begin
                    r_p <= w_shift;
                end
                S_SH2: begin
                    r_p <= w_shift;
                    if (w_last) begin
                        r_product <= w_shift[2*WIDTH:1];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// tb/tb_booth_r4_ctrl.sv - scoreboard testbench for booth_r4_ctrl at WIDTH=8
module tb_booth_r4_ctrl;
    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [W-1:0]    i_multiplicand = '0;
    logic [W-1:0]    i_multiplier = '0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    logic [2*W-1:0]  o_product;
    logic            o_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit soak = 1'b0;
    bit prev_v = 1'b0;

    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    booth_r4_ctrl #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_product      (o_product),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: latency of each accept and product value at each output handshake
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
        end else begin
            if (i_valid && o_ready) acc_q.push_back(cyc + 1);
            if (o_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    chk("output_without_accept", 32'd1, 32'd0);
                end else begin
                    chk("latency", 32'(cyc - acc_q.pop_front()), 32'd12);
                end
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {16'd0, o_product}, 32'hFFFF_FFFF);
                end else begin
                    chk("product", {16'd0, o_product}, {16'd0, exp_q.pop_front()});
                end
            end
        end
        prev_v = o_valid;
    end

    // Random output backpressure during the soak phase
    always @(posedge clk) begin
        if (soak) begin
            #1 i_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input bit push);
        bit ok = 1'b0;
        @(posedge clk); #1;
        i_multiplicand = m;
        i_multiplier   = q;
        i_valid        = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        else if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_ready && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'd3,   8'd5,   16'h000F});
        vecs.push_back('{8'h80,  8'h80,  16'h4000});
        vecs.push_back('{8'h80,  8'h7F,  16'hC080});
        vecs.push_back('{8'hFF,  8'hFF,  16'h0001});
        vecs.push_back('{8'h00,  8'hB3,  16'h0000});
        vecs.push_back('{8'hF9,  8'h6B,  16'hFD13});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",   {31'd0, o_ready}, 32'd1);
        chk("reset_valid",   {31'd0, o_valid}, 32'd0);
        chk("reset_busy",    {31'd0, o_busy},  32'd0);
        chk("reset_product", {16'd0, o_product}, 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].m, vecs[i].q, vecs[i].p, 1'b1);
            wait_idle();
        end

        // Reset asserted while the op sits in SH1: no product, outputs cleared
        issue(8'd9, 8'd9, 16'd81, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready",   {31'd0, o_ready}, 32'd1);
        chk("midrst_valid",   {31'd0, o_valid}, 32'd0);
        chk("midrst_product", {16'd0, o_product}, 32'd0);
        repeat (20) @(negedge clk);
        chk("midrst_no_output", {31'd0, o_valid}, 32'd0);

        // Output backpressure: product held, inputs ignored, release returns to IDLE
        i_ready = 1'b0;
        issue(8'hF9, 8'h6B, 16'hFD13, 1'b1);
        for (int i = 0; i < 40 && !o_valid; i++) @(negedge clk);
        chk("bp_valid_seen", {31'd0, o_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            i_valid        = 1'b1;
            i_multiplicand = 8'(k + 1);
            i_multiplier   = 8'(k + 2);
            @(negedge clk);
            chk("bp_valid",   {31'd0, o_valid}, 32'd1);
            chk("bp_ready",   {31'd0, o_ready}, 32'd0);
            chk("bp_product", {16'd0, o_product}, 32'h0000FD13);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", {31'd0, o_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, o_valid}, 32'd0);
        chk("bp_hold_after",    {16'd0, o_product}, 32'h0000FD13);

        // Random soak against a signed multiply reference
        soak = 1'b1;
        for (int n = 0; n < 200; n++) begin
            logic [W-1:0]   m;
            logic [W-1:0]   q;
            logic [2*W-1:0] p;
            m = W'($urandom);
            q = W'($urandom);
            p = 16'($signed(m) * $signed(q));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(m, q, p, 1'b1);
        end
        soak = 1'b0;
        @(posedge clk); #2 i_ready = 1'b1;
        wait_idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
